// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the clocked instruction memory fetch block.
// Holds the fetch FSM encoding, the blank-word constant and sizing defaults.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
  localparam int          MAX_WAIT_STATES = 7;
  localparam int          DEFAULT_DEPTH   = 128;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction ROM with image rom[i] = i*3 and a registered, enable-gated read port.
// One-cycle read latency; the output word holds while rd_en is low.
module instr_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_word
);

  logic [DATA_WIDTH-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = DATA_WIDTH'(g * 3);
  end

  // Only the read register is reset; the image itself is constant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= rom[rd_idx];
    end
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Clocked instruction fetch: Req/Ready accept, Valid pulse WAIT_STATES+1 cycles later.
// Optional misaligned-address Fault output enabled by INSTR_MEM_MISALIGN_CHECK_EN.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Req,
  input  logic [ADDR_WIDTH-1:0] Address,
  output logic                  Ready,
  output logic                  Valid,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [ADDR_WIDTH-1:0] RespAddress,
  output logic                  OutOfRange
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
  ,
  output logic                  Fault
`endif
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;

  state_t                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, resp_addr_q, src_addr;
  logic [IDX_W-1:0]        src_idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    accept, enter_resp, src_oor, blank_nxt, oor_q, blank_q;

  assign Ready  = (state == IDLE) || (state == RESP);
  assign Valid  = (state == RESP);
  assign accept = Req && Ready;

  // A zero-wait accept reads straight from the bus; otherwise the latched address is used.
  assign src_addr   = accept ? Address : addr_q;
  assign src_idx    = src_addr[IDX_W+1:2];
  assign src_oor    = |src_addr[ADDR_WIDTH-1:IDX_W+2];
  assign enter_resp = (state_nxt == RESP);

`ifdef INSTR_MEM_MISALIGN_CHECK_EN
  logic src_mis, fault_q;
  assign src_mis   = |src_addr[1:0];
  assign blank_nxt = src_oor | src_mis;
  assign Fault     = fault_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fault_q <= 1'b0;
    end else if (enter_resp) begin
      fault_q <= src_mis;
    end
  end
`else
  assign blank_nxt = src_oor;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          cnt_nxt   = 3'(WS_EFF);
          state_nxt = (WS_EFF == 0) ? RESP : WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          cnt_nxt   = 3'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      resp_addr_q <= '0;
      oor_q       <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= Address;
      end
      if (enter_resp) begin
        resp_addr_q <= src_addr;
        oor_q       <= src_oor;
        blank_q     <= blank_nxt;
      end
    end
  end

  instr_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .rd_en   (enter_resp),
    .rd_idx  (src_idx),
    .rd_word (rd_word)
  );

  // Faulted or out-of-range responses return the blank word regardless of the ROM read.
  assign Instruction = blank_q ? DATA_WIDTH'(NOP_WORD) : rd_word;
  assign RespAddress = resp_addr_q;
  assign OutOfRange  = oor_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: three instances (WAIT_STATES 0, 2, 3) on shared stimulus,
// checked each cycle against a transaction-level model plus directed expectations.
module tb_instr_mem_fetch;

  localparam int NDUT  = 3;
  localparam int DEPTH = 128;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Req;
  logic [31:0] Address;

  logic        rdy   [NDUT];
  logic        vld   [NDUT];
  logic        oor   [NDUT];
  logic [31:0] instr [NDUT];
  logic [31:0] raddr [NDUT];
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
  logic        flt   [NDUT];
`endif

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    instr_mem_fetch #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .DEPTH       (DEPTH),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .Req         (Req),
      .Address     (Address),
      .Ready       (rdy[g]),
      .Valid       (vld[g]),
      .Instruction (instr[g]),
      .RespAddress (raddr[g]),
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
      .Fault       (flt[g]),
`endif
      .OutOfRange  (oor[g])
    );
  end

  int n_run  = 0;
  int n_fail = 0;

  // Transaction model: one outstanding fetch per instance with an absolute due cycle.
  int          cyc;
  bit          m_pend  [NDUT];
  int          m_due   [NDUT];
  logic [31:0] m_paddr [NDUT];
  logic [31:0] m_instr [NDUT];
  logic [31:0] m_raddr [NDUT];
  logic        m_oor   [NDUT];
  logic        m_flt   [NDUT];

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic ref_oor(logic [31:0] a);
    return a >= 32'(DEPTH * 4);
  endfunction

  function automatic logic ref_flt(logic [31:0] a);
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a);
    if (ref_oor(a)) return 32'd0;
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
    if (ref_flt(a)) return 32'd0;
`endif
    return (a / 4) * 3;
  endfunction

  function automatic logic m_ready(int k);
    return !(m_pend[k] && cyc < m_due[k]);
  endfunction

  function automatic logic m_valid(int k);
    return m_pend[k] && (m_due[k] == cyc);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_pend[k]  = 1'b0;
      m_due[k]   = 0;
      m_paddr[k] = '0;
      m_instr[k] = '0;
      m_raddr[k] = '0;
      m_oor[k]   = 1'b0;
      m_flt[k]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit acc [NDUT];
    if (!Reset_n) begin
      model_reset();
      cyc++;
      return;
    end
    for (int k = 0; k < NDUT; k++) acc[k] = Req && m_ready(k);
    for (int k = 0; k < NDUT; k++) begin
      if (m_pend[k] && m_due[k] <= cyc) m_pend[k] = 1'b0;
      if (acc[k]) begin
        m_pend[k]  = 1'b1;
        m_due[k]   = cyc + 1 + ws_of(k);
        m_paddr[k] = Address;
      end
    end
    cyc++;
    for (int k = 0; k < NDUT; k++) begin
      if (m_valid(k)) begin
        m_instr[k] = ref_word(m_paddr[k]);
        m_raddr[k] = m_paddr[k];
        m_oor[k]   = ref_oor(m_paddr[k]);
        m_flt[k]   = ref_flt(m_paddr[k]);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(m_ready(k)));
      chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(m_valid(k)));
      chk($sformatf("instr%0d", k), instr[k], m_instr[k]);
      chk($sformatf("raddr%0d", k), raddr[k], m_raddr[k]);
      chk($sformatf("oor%0d", k), 32'(oor[k]), 32'(m_oor[k]));
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
      chk($sformatf("fault%0d", k), 32'(flt[k]), 32'(m_flt[k]));
`endif
    end
  endtask

  task automatic step(input logic r, input logic [31:0] a);
    Req     = r;
    Address = a;
    check_all();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0);
  endtask

  task automatic mid_reset();
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      model_edge();
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    logic        r;
    logic [31:0] a;
    int          sel;

    cyc     = 0;
    Reset_n = 1'b0;
    Req     = 1'b0;
    Address = '0;
    model_reset();
    #1;
    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_instr", instr[0], 32'd0);
    chk("rst_raddr", raddr[2], 32'd0);
    chk("rst_ready", 32'(rdy[1]), 32'd1);
    check_all();
    repeat (2) begin
      @(posedge Clk);
      model_edge();
    end
    @(negedge Clk);
    Reset_n = 1'b1;

    // Separate accepts at zero wait states.
    step(1'b1, 32'd0);
    chk("sep0_valid", 32'(vld[0]), 32'd1);
    chk("sep0_instr", instr[0], 32'd0);
    step(1'b0, 32'd0);
    chk("sep0_pulse", 32'(vld[0]), 32'd0);
    step(1'b1, 32'd20);
    chk("sep20_instr", instr[0], 32'd15);
    chk("sep20_raddr", raddr[0], 32'd20);
    step(1'b0, 32'd0);
    step(1'b1, 32'd40);
    chk("sep40_instr", instr[0], 32'd30);
    chk("sep40_raddr", raddr[0], 32'd40);
    idle(6);

    // Back-to-back at zero wait states.
    step(1'b1, 32'd0);
    chk("b2b0_valid", 32'(vld[0]), 32'd1);
    chk("b2b0_ready", 32'(rdy[0]), 32'd1);
    chk("b2b0_instr", instr[0], 32'd0);
    step(1'b1, 32'd4);
    chk("b2b4_valid", 32'(vld[0]), 32'd1);
    chk("b2b4_instr", instr[0], 32'd3);
    step(1'b1, 32'd8);
    chk("b2b8_valid", 32'(vld[0]), 32'd1);
    chk("b2b8_instr", instr[0], 32'd6);
    step(1'b0, 32'd0);
    chk("b2b_end_valid", 32'(vld[0]), 32'd0);
    chk("b2b_hold_instr", instr[0], 32'd6);
    idle(6);

    // Two wait states; a request during WAIT is dropped.
    step(1'b1, 32'd12);
    chk("ws2_ready_a", 32'(rdy[1]), 32'd0);
    step(1'b1, 32'd16);
    chk("ws2_ready_b", 32'(rdy[1]), 32'd0);
    chk("ws2_novalid", 32'(vld[1]), 32'd0);
    step(1'b0, 32'd0);
    chk("ws2_valid", 32'(vld[1]), 32'd1);
    chk("ws2_instr", instr[1], 32'd9);
    chk("ws2_raddr", raddr[1], 32'd12);
    step(1'b0, 32'd0);
    chk("ws2_drop_valid", 32'(vld[1]), 32'd0);
    chk("ws2_drop_instr", instr[1], 32'd9);
    idle(6);

    // Range boundary.
    step(1'b1, 32'd512);
    chk("oor_valid", 32'(vld[0]), 32'd1);
    chk("oor_instr", instr[0], 32'd0);
    chk("oor_flag", 32'(oor[0]), 32'd1);
    step(1'b1, 32'd508);
    chk("last_instr", instr[0], 32'd381);
    chk("last_flag", 32'(oor[0]), 32'd0);
    idle(6);

    // Reset in the middle of a three-wait-state fetch.
    step(1'b1, 32'd8);
    step(1'b0, 32'd0);
    mid_reset();
    chk("abort_ready", 32'(rdy[2]), 32'd1);
    chk("abort_instr", instr[2], 32'd0);
    chk("abort_valid", 32'(vld[2]), 32'd0);
    step(1'b1, 32'd8);
    idle(5);
    chk("refetch_instr", instr[2], 32'd6);
    chk("refetch_raddr", raddr[2], 32'd8);

    // Misaligned address.
    step(1'b1, 32'd6);
`ifdef INSTR_MEM_MISALIGN_CHECK_EN
    chk("mis_fault", 32'(flt[0]), 32'd1);
    chk("mis_instr", instr[0], 32'd0);
`else
    chk("mis_instr", instr[0], 32'd3);
`endif
    idle(5);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      else if (sel < 8)  a = 32'($urandom_range(0, 511));
      else if (sel == 8) a = 32'd512 + 32'd4 * 32'($urandom_range(0, 1000));
      else               a = $urandom;
      step(r, a);
      if ($urandom_range(0, 79) == 0) mid_reset();
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
Parametrised, clocked successor to the combinational instruction memory. It accepts byte-addressed fetch requests through a Req/Ready handshake and returns the word after a configurable number of wait states, with a one-cycle Valid pulse. It sits between the program counter and the IF/ID pipeline register. The default image is mem[i] = i*3, so existing directed checks keep their expected values.

Parameters:
DATA_WIDTH, 32, instruction word width in bits
ADDR_WIDTH, 32, byte address width
DEPTH, 128, number of words; power of 2; IDX_W = log2(DEPTH)
WAIT_STATES, 0, extra cycles between accept and Valid; legal range 0..7

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
Req  in  1  fetch request; qualified by Ready
Address  in  ADDR_WIDTH  byte address of the fetch
Ready  out  1  block can accept a request this cycle
Valid  out  1  Instruction/RespAddress valid; one-cycle pulse
Instruction  out  DATA_WIDTH  fetched word
RespAddress  out  ADDR_WIDTH  byte address that produced Instruction
OutOfRange  out  1  qualified by Valid; address was beyond DEPTH words
Fault  out  1  only with the macro; qualified by Valid; address was misaligned

Behaviour:
- Reset is async and active-low. Valid=0, Instruction=0, RespAddress=0, OutOfRange=0, Fault=0, and the state goes to IDLE. Memory contents are not affected by reset.
- Memory initialises to mem[i] = i*3 for all i < DEPTH.
- Word index is Address[IDX_W+1:2].
- If Address[ADDR_WIDTH-1:IDX_W+2] != 0, the response is Instruction=0 and OutOfRange=1.
- FSM has three states: IDLE, WAIT, RESP.
  - Ready = (state==IDLE) || (state==RESP).
  - Accept = Req && Ready. On accept, the block latches Address and loads the counter with WAIT_STATES.
  - If the accept happens with WAIT_STATES=0, the next state is RESP.
  - Otherwise the next state is WAIT. WAIT decrements the counter and moves to RESP on the cycle after the counter reaches 1.
  - In RESP, Valid=1 for exactly that cycle. Instruction, RespAddress and the flags update on entry to RESP.
  - From RESP: on accept, go to WAIT or RESP as above, which gives back-to-back throughput of 1 word per cycle at WAIT_STATES=0. Otherwise go to IDLE.
- Latency is WAIT_STATES+1 cycles from the accepting edge to the cycle in which Valid is high.
- After the Valid pulse, Instruction, RespAddress and the flags hold their values until the next response.
- Req while Ready=0 (WAIT state) is ignored and is not queued. The requester must hold Req until Ready.
- There is no backpressure on the response. The consumer must take the data in the Valid cycle.
- Reset asserted mid-operation aborts the in-flight fetch: no Valid is produced and outputs return to reset values immediately.
- A change on Address while not accepted has no effect. The latched address is used for the whole transaction.

Optional Feature:
Macro: INSTR_MEM_MISALIGN_CHECK_EN.
- Defined: Fault port exists. Address[1:0] != 0 yields a response with Fault=1 and Instruction=0. The latency is unchanged. If both misaligned and out of range, Fault=1 and OutOfRange=1.
- Undefined: no Fault port. Address[1:0] is ignored, so the fetch uses word index Address[IDX_W+1:2].

Decomposition:
- Shared package instr_mem_pkg holds:
  - the state encoding typedef (IDLE/WAIT/RESP);
  - the NOP/zero-word constant;
  - the WAIT_STATES maximum;
  - the default DEPTH.
- One sub-module, instr_mem_array: the memory array with its i*3 initialisation and a registered read port (index in, word out). Top level holds the FSM, counter, address latch and flags.

Test Plan:
- WAIT_STATES=0, Req with Address=0, then 20, then 40 on separate accepts -> Valid one cycle after each accept; Instruction = 0, 15, 30; RespAddress matches each request.
- WAIT_STATES=0, Req held high with Address=0,4,8 on consecutive cycles -> Ready stays 1; Valid high 3 consecutive cycles; Instruction = 0, 3, 6.
- WAIT_STATES=2, accept Address=12 -> Ready=0 for 2 cycles; Valid in the 3rd cycle after the accepting edge with Instruction=9; a Req during WAIT with Address=16 produces no response.
- DEPTH=128, Address=512 -> Valid with Instruction=0 and OutOfRange=1; next Address=508 -> Instruction=381 and OutOfRange=0.
- WAIT_STATES=3, accept Address=8, drop Reset_n one cycle later -> Valid never asserts; Instruction=0 and Ready=1 after release; the next fetch of Address=8 returns 6.
- Misaligned Address=6: with INSTR_MEM_MISALIGN_CHECK_EN -> Fault=1, Instruction=0; without the macro -> Instruction=3.
